// File: rtl/mig_pkg.sv
// Shared constants for the MIG application-interface bridge: command codes,
// FSM state encodings and default widths/limits.
package mig_pkg;

    localparam int ADDR_WIDTH_DEF     = 28;
    localparam int APP_DATA_WIDTH_DEF = 128;
    localparam int APP_MASK_WIDTH_DEF = APP_DATA_WIDTH_DEF / 8;

    // First byte address beyond the 256 MB DDR3 device.
    localparam logic [31:0] MEM_LIMIT_DEF = 32'h1000_0000;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_RD_CMD  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_WR_CMD  = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

endpackage

// File: rtl/mig_app_bridge_if.sv
// MIG user-interface (app_*) signal bundle; the bridge is the master,
// the MIG core (or a model of it) is the slave.
interface mig_app_bridge_if
    import mig_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int APP_DATA_WIDTH = APP_DATA_WIDTH_DEF,
    parameter int APP_MASK_WIDTH = APP_MASK_WIDTH_DEF
);
    logic [ADDR_WIDTH-1:0]     app_addr;
    logic [2:0]                app_cmd;
    logic                      app_en;
    logic                      app_rdy;
    logic [APP_DATA_WIDTH-1:0] app_wdf_data;
    logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic                      app_wdf_rdy;
    logic [APP_DATA_WIDTH-1:0] app_rd_data;
    logic                      app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/mig_lane_select.sv
// Maps a 32-bit word lane onto a wide MIG burst: write-data replication,
// inverted byte mask for the selected lane, and read-word extraction.
module mig_lane_select
    import mig_pkg::*;
#(
    parameter int APP_DATA_WIDTH = APP_DATA_WIDTH_DEF,
    parameter int APP_MASK_WIDTH = APP_MASK_WIDTH_DEF,
    parameter int LANE_BITS      = $clog2(APP_DATA_WIDTH / 32)
)(
    input  logic [LANE_BITS-1:0]      lane,
    input  logic [31:0]               wdata,
    input  logic [APP_DATA_WIDTH-1:0] rd_data,
    output logic [APP_DATA_WIDTH-1:0] wdata_rep,
    output logic [APP_MASK_WIDTH-1:0] wmask,
    output logic [31:0]               rword
);
    localparam int LANES = APP_DATA_WIDTH / 32;

    logic [31:0] words [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wdata_rep[32*gi +: 32] = wdata;
            // MIG mask polarity: 1 means the byte is left untouched.
            assign wmask[4*gi +: 4]       = (lane == LANE_BITS'(gi)) ? 4'h0 : 4'hF;
            assign words[gi]              = rd_data[32*gi +: 32];
        end
    endgenerate

    assign rword = words[lane];

endmodule

// File: rtl/mig_app_bridge.sv
// Single-outstanding-request bridge from the core's 32-bit load/store port
// to the 128-bit MIG DDR3 application interface.
module mig_app_bridge
    import mig_pkg::*;
#(
    parameter int          ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int          APP_DATA_WIDTH = APP_DATA_WIDTH_DEF,
    parameter int          APP_MASK_WIDTH = APP_MASK_WIDTH_DEF,
    parameter logic [31:0] MEM_LIMIT      = MEM_LIMIT_DEF
)(
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    input  logic              init_calib_complete,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    mig_app_bridge_if.master  app
);
    logic [2:0]                state_reg;
    logic [1:0]                lane_reg;
    logic [ADDR_WIDTH-1:0]     app_addr_reg;
    logic [2:0]                app_cmd_reg;
    logic                      app_en_reg;
    logic                      app_wdf_wren_reg;
    logic [APP_DATA_WIDTH-1:0] app_wdf_data_reg;
    logic [APP_MASK_WIDTH-1:0] app_wdf_mask_reg;
    logic                      resp_valid_reg;
    logic                      resp_err_reg;
    logic [31:0]               resp_rdata_reg;

    logic [1:0]                lane_sel;
    logic [APP_DATA_WIDTH-1:0] wdata_rep;
    logic [APP_MASK_WIDTH-1:0] wmask;
    logic [31:0]               rword;
    logic                      cmd_done;
    logic                      data_done;

    assign req_ready = (state_reg == ST_IDLE);
    // Incoming lane while accepting, latched lane while the burst is in flight.
    assign lane_sel  = (state_reg == ST_IDLE) ? req_addr[3:2] : lane_reg;

    // A strobe already dropped counts as done, so the two write handshakes
    // may finish in either order or together.
    assign cmd_done  = !app_en_reg || app.app_rdy;
    assign data_done = !app_wdf_wren_reg || app.app_wdf_rdy;

    mig_lane_select #(
        .APP_DATA_WIDTH (APP_DATA_WIDTH),
        .APP_MASK_WIDTH (APP_MASK_WIDTH),
        .LANE_BITS      (2)
    ) u_lane_select (
        .lane      (lane_sel),
        .wdata     (req_wdata),
        .rd_data   (app.app_rd_data),
        .wdata_rep (wdata_rep),
        .wmask     (wmask),
        .rword     (rword)
    );

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state_reg        <= ST_INIT;
            lane_reg         <= '0;
            app_addr_reg     <= '0;
            app_cmd_reg      <= 3'b000;
            app_en_reg       <= 1'b0;
            app_wdf_wren_reg <= 1'b0;
            app_wdf_data_reg <= '0;
            app_wdf_mask_reg <= '1;
            resp_valid_reg   <= 1'b0;
            resp_err_reg     <= 1'b0;
            resp_rdata_reg   <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                ST_INIT: begin
                    if (init_calib_complete) state_reg <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        lane_reg       <= req_addr[3:2];
                        app_addr_reg   <= {req_addr[ADDR_WIDTH:4], 3'b000};
                        resp_rdata_reg <= '0;
                        resp_err_reg   <= 1'b0;
                        if (req_addr >= MEM_LIMIT) begin
                            resp_err_reg <= 1'b1;
                            state_reg    <= ST_RESP;
                        end else if (req_we) begin
                            app_cmd_reg      <= CMD_WRITE;
                            app_en_reg       <= 1'b1;
                            app_wdf_wren_reg <= 1'b1;
                            app_wdf_data_reg <= wdata_rep;
                            app_wdf_mask_reg <= wmask;
                            state_reg        <= ST_WR_CMD;
                        end else begin
                            app_cmd_reg <= CMD_READ;
                            app_en_reg  <= 1'b1;
                            state_reg   <= ST_RD_CMD;
                        end
                    end
                end
                ST_RD_CMD: begin
                    if (app.app_rdy) begin
                        app_en_reg <= 1'b0;
                        state_reg  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (app.app_rd_data_valid) begin
                        resp_rdata_reg <= rword;
                        resp_err_reg   <= 1'b0;
                        state_reg      <= ST_RESP;
                    end
                end
                ST_WR_CMD: begin
                    if (app.app_rdy)     app_en_reg       <= 1'b0;
                    if (app.app_wdf_rdy) app_wdf_wren_reg <= 1'b0;
                    if (cmd_done && data_done) begin
                        resp_rdata_reg <= '0;
                        state_reg      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_IDLE;
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    assign resp_valid       = resp_valid_reg;
    assign resp_rdata       = resp_rdata_reg;
    assign resp_err         = resp_err_reg;
    assign app.app_addr     = app_addr_reg;
    assign app.app_cmd      = app_cmd_reg;
    assign app.app_en       = app_en_reg;
    assign app.app_wdf_data = app_wdf_data_reg;
    assign app.app_wdf_mask = app_wdf_mask_reg;
    assign app.app_wdf_wren = app_wdf_wren_reg;
    assign app.app_wdf_end  = 1'b1;

endmodule

// File: tb/tb_mig_app_bridge.sv
// Scoreboard bench for mig_app_bridge: expected commands, write beats and
// responses are queued at stimulus time and popped by a negedge monitor.
module tb_mig_app_bridge;
    import mig_pkg::*;

    logic        ui_clk = 1'b0;
    logic        ui_clk_sync_rst = 1'b1;
    logic        init_calib_complete = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    mig_app_bridge_if app_bus ();

    mig_app_bridge dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .req_valid           (req_valid),
        .req_we              (req_we),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_ready           (req_ready),
        .resp_valid          (resp_valid),
        .resp_rdata          (resp_rdata),
        .resp_err            (resp_err),
        .app                 (app_bus)
    );

    always #5 ui_clk = ~ui_clk;

    typedef struct { logic [31:0] rdata; logic err; int lat; bit is_read; } resp_t;
    typedef struct { logic [27:0] addr; logic [2:0] cmd; } cmd_t;
    typedef struct { logic [127:0] data; logic [15:0] mask; } wr_t;

    resp_t exp_resp[$];
    cmd_t  exp_cmd[$];
    wr_t   exp_wr[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rdv_cyc = 0;
    int resp_count = 0;
    int cmd_hs = 0;
    int wr_hs = 0;
    int en_cycles = 0;
    int wren_cycles = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge ui_clk);
        cyc++;
    end

    // Monitor: scores every MIG handshake and every response.
    initial begin : monitor
        cmd_t  c;
        wr_t   w;
        resp_t r;
        forever begin
            @(negedge ui_clk);
            if (!ui_clk_sync_rst) begin
                if (req_valid && req_ready) acc_cyc = cyc;
                if (app_bus.app_rd_data_valid) rdv_cyc = cyc;
                if (app_bus.app_en) en_cycles++;
                if (app_bus.app_wdf_wren) wren_cycles++;
                if (app_bus.app_en && app_bus.app_rdy) begin
                    cmd_hs++;
                    if (exp_cmd.size() == 0) check("cmd_unexpected", 1, 0);
                    else begin
                        c = exp_cmd.pop_front();
                        check("cmd_addr", app_bus.app_addr, c.addr);
                        check("cmd_type", app_bus.app_cmd, c.cmd);
                    end
                end
                if (app_bus.app_wdf_wren && app_bus.app_wdf_rdy) begin
                    wr_hs++;
                    if (exp_wr.size() == 0) check("wdf_unexpected", 1, 0);
                    else begin
                        w = exp_wr.pop_front();
                        check("wdf_data", app_bus.app_wdf_data, w.data);
                        check("wdf_mask", app_bus.app_wdf_mask, w.mask);
                        check("wdf_end", app_bus.app_wdf_end, 1);
                    end
                end
                if (resp_valid) begin
                    resp_count++;
                    $display("[TB] resp %0d: rdata=%08h err=%0b cycle=%0d", resp_count, resp_rdata, resp_err, cyc);
                    if (exp_resp.size() == 0) check("resp_unexpected", 1, 0);
                    else begin
                        r = exp_resp.pop_front();
                        check("resp_rdata", resp_rdata, r.rdata);
                        check("resp_err", resp_err, r.err);
                        if (r.is_read) check("resp_lat_rd", cyc - rdv_cyc, 2);
                        else           check("resp_lat", cyc - acc_cyc, r.lat);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bit ok = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ui_clk);
            if (req_ready) ok = 1;
        end
        tick();
        req_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_resp(input int n0, input string tag);
        int i = 0;
        while (resp_count == n0 && i < 200) begin tick(); i++; end
        if (resp_count == n0) check(tag, 0, 1);
    endtask

    task automatic wait_cmd(input int c0);
        int i = 0;
        while (cmd_hs == c0 && i < 100) begin tick(); i++; end
        if (cmd_hs == c0) check("cmd_timeout", 0, 1);
    endtask

    task automatic mig_return(input logic [127:0] data, input int delay);
        repeat (delay) tick();
        app_bus.app_rd_data = data;
        app_bus.app_rd_data_valid = 1'b1;
        tick();
        app_bus.app_rd_data_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [27:0] exp_addr,
                           input logic [127:0] data, input logic [31:0] exp_word, input int delay);
        int c0 = cmd_hs;
        int r0 = resp_count;
        exp_cmd.push_back('{exp_addr, CMD_READ});
        exp_resp.push_back('{exp_word, 1'b0, 0, 1'b1});
        issue(1'b0, addr, 32'h0);
        wait_cmd(c0);
        mig_return(data, delay);
        wait_resp(r0, "read_resp_timeout");
    endtask

    initial begin : main
        int gate_bad;
        int r0, c0, en0, wren0, wr0;
        app_bus.app_rdy = 1'b0;
        app_bus.app_wdf_rdy = 1'b0;
        app_bus.app_rd_data = '0;
        app_bus.app_rd_data_valid = 1'b0;
        repeat (4) tick();

        // Reset values
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_app_en", app_bus.app_en, 0);
        check("rst_wren", app_bus.app_wdf_wren, 0);
        check("rst_app_cmd", app_bus.app_cmd, 0);
        check("rst_app_addr", app_bus.app_addr, 0);
        check("rst_wdf_data", app_bus.app_wdf_data, 0);
        check("rst_wdf_mask", app_bus.app_wdf_mask, 16'hFFFF);
        ui_clk_sync_rst = 1'b0;

        // Calibration gate
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
        gate_bad = 0;
        repeat (6) begin
            @(negedge ui_clk);
            if (req_ready || app_bus.app_en) gate_bad++;
        end
        check("calib_gate", gate_bad, 0);
        tick();
        init_calib_complete = 1'b1;
        exp_cmd.push_back('{28'h080, CMD_READ});
        exp_resp.push_back('{32'h0A0A0A0A, 1'b0, 0, 1'b1});
        c0 = cmd_hs; r0 = resp_count;
        issue(1'b0, 32'h100, 32'h0);
        check("calib_app_en", app_bus.app_en, 1);
        check("calib_app_addr", app_bus.app_addr, 28'h080);
        check("calib_app_cmd", app_bus.app_cmd, 3'b001);
        app_bus.app_rdy = 1'b1;
        wait_cmd(c0);
        mig_return(128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 3);
        wait_resp(r0, "calib_resp_timeout");

        // Write to lane 2, both ready
        app_bus.app_wdf_rdy = 1'b1;
        r0 = resp_count; wr0 = wr_hs;
        exp_cmd.push_back('{28'h008, CMD_WRITE});
        exp_wr.push_back('{{4{32'hDEADBEEF}}, 16'hF0FF});
        exp_resp.push_back('{32'h0, 1'b0, 3, 1'b0});
        issue(1'b1, 32'h0000_0018, 32'hDEADBEEF);
        wait_resp(r0, "wr_resp_timeout");
        repeat (3) tick();
        check("wr_single_beat", wr_hs - wr0, 1);

        // Split handshake: data FIFO ready only in T+5
        app_bus.app_wdf_rdy = 1'b0;
        r0 = resp_count; wr0 = wr_hs; en0 = en_cycles; wren0 = wren_cycles;
        exp_cmd.push_back('{28'h010, CMD_WRITE});
        exp_wr.push_back('{{4{32'h12345678}}, 16'hFF0F});
        exp_resp.push_back('{32'h0, 1'b0, 7, 1'b0});
        issue(1'b1, 32'h0000_0024, 32'h12345678);
        repeat (4) tick();
        app_bus.app_wdf_rdy = 1'b1;
        tick();
        app_bus.app_wdf_rdy = 1'b0;
        wait_resp(r0, "split_resp_timeout");
        repeat (3) tick();
        check("split_en_cycles", en_cycles - en0, 1);
        check("split_wren_cycles", wren_cycles - wren0, 5);
        check("split_single_beat", wr_hs - wr0, 1);
        app_bus.app_wdf_rdy = 1'b1;

        // Read extraction from lane 3 with a long MIG latency
        do_read(32'h0000_001C, 28'h008, 128'h44444444_33333333_22222222_11111111, 32'h44444444, 10);

        // Range errors: no MIG traffic, response at T+2
        en0 = en_cycles; wren0 = wren_cycles; r0 = resp_count;
        exp_resp.push_back('{32'h0, 1'b1, 2, 1'b0});
        issue(1'b0, 32'h1000_0000, 32'h0);
        wait_resp(r0, "err_rd_timeout");
        r0 = resp_count;
        exp_resp.push_back('{32'h0, 1'b1, 2, 1'b0});
        issue(1'b1, 32'hFFFF_FFF0, 32'hCAFEF00D);
        wait_resp(r0, "err_wr_timeout");
        repeat (2) tick();
        check("err_no_app_en", en_cycles - en0, 0);
        check("err_no_wren", wren_cycles - wren0, 0);
        do_read(32'h0FFF_FFFC, 28'h7FF_FFF8, 128'h89ABCDEF_76543210_FEDCBA98_01234567, 32'h89ABCDEF, 4);

        // Reset while waiting for read data
        c0 = cmd_hs;
        exp_cmd.push_back('{28'h010, CMD_READ});
        issue(1'b0, 32'h0000_0020, 32'h0);
        wait_cmd(c0);
        repeat (2) tick();
        ui_clk_sync_rst = 1'b1;
        repeat (2) tick();
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_app_en", app_bus.app_en, 0);
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_wdf_mask", app_bus.app_wdf_mask, 16'hFFFF);
        check("mid_rst_wdf_data", app_bus.app_wdf_data, 0);
        check("mid_rst_app_addr", app_bus.app_addr, 0);
        ui_clk_sync_rst = 1'b0;
        r0 = resp_count;
        mig_return(128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0, 1);
        repeat (6) tick();
        check("stray_data_no_resp", resp_count - r0, 0);
        do_read(32'h0000_0034, 28'h018, 128'h00000004_00000003_5A5A5A5A_00000001, 32'h5A5A5A5A, 2);

        repeat (3) tick();
        check("resp_queue_empty", exp_resp.size(), 0);
        check("cmd_queue_empty", exp_cmd.size(), 0);
        check("wr_queue_empty", exp_wr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
        $fatal(1);
    end

endmodule
